// File: rtl/seq_divider32x16.sv
// ---------------------------------------------------------------------------
// seq_divider32x16
//   Sequential signed divider: 32-bit dividend / 16-bit divisor. It uses a
//   restoring, MSB-first algorithm that retires one quotient bit per cycle.
//   The quotient rounds toward zero, and the remainder takes the sign of the
//   dividend.
//   The latency is fixed: out_valid rises 34 clock edges after the accepting
//   edge (1 SETUP + 32 ITER + 1 FIX). This holds for every operand pair,
//   including the divide-by-zero and overflow cases.
//
// Ports
//   clk          : clock, rising edge
//   rst          : synchronous, active-high reset
//   dividend     : signed 32-bit dividend, captured on acceptance
//   divisor      : signed 16-bit divisor, captured on acceptance
//   in_valid     : requester offers an operand pair
//   in_ready     : high only while idle
//   quotient     : signed 32-bit quotient   (valid with out_valid)
//   remainder    : signed 16-bit remainder  (valid with out_valid)
//   div_by_zero  : divisor was zero         (valid with out_valid)
//   overflow     : 0x80000000 / -1          (valid with out_valid)
//   out_valid    : result available, held until out_ready
//   out_ready    : consumer takes the result
// ---------------------------------------------------------------------------
module seq_divider32x16 (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dividend,
   input  logic [15:0] divisor,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] quotient,
   output logic [15:0] remainder,
   output logic        div_by_zero,
   output logic        overflow,
   output logic        out_valid,
   input  logic        out_ready
);

   typedef enum logic [2:0] {IDLE, SETUP, ITER, FIX, DONE} state_t;

   state_t             state;
   logic signed [31:0] dvd_in;    // captured operands
   logic signed [15:0] dvs_in;
   logic [31:0]        shq;       // dividend magnitude shifts out, quotient bits shift in
   logic [15:0]        dvs_mag;   // up to 32768, so 16 unsigned bits suffice
   logic [15:0]        prem;      // partial remainder, always < dvs_mag
   logic [4:0]         cnt;
   logic               sign_q;
   logic               sign_r;

   logic [16:0]        shifted;
   logic               ge;
   logic [15:0]        diff;

   function automatic logic [31:0] abs32(input logic signed [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [15:0] abs16(input logic signed [15:0] v);
      return v[15] ? (~v + 16'd1) : v;
   endfunction

   function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [15:0] cond_neg16(input logic [15:0] v, input logic neg);
      return neg ? (~v + 16'd1) : v;
   endfunction

   // A 17-bit trial compare decides the quotient bit. Whenever the
   // subtraction is kept, the true difference is below 32768, so the low
   // 16 bits of the difference are exact.
   always_comb begin
      shifted = {prem, shq[31]};
      ge      = (shifted >= {1'b0, dvs_mag});
      diff    = shifted[15:0] - dvs_mag;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  dvd_in   <= dividend;
                  dvs_in   <= divisor;
                  in_ready <= 1'b0;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               shq     <= abs32(dvd_in);
               dvs_mag <= abs16(dvs_in);
               sign_q  <= dvd_in[31] ^ dvs_in[15];
               sign_r  <= dvd_in[31];
               prem    <= '0;
               cnt     <= '0;
               state   <= ITER;
            end
            ITER: begin
               prem  <= ge ? diff : shifted[15:0];
               shq   <= {shq[30:0], ge};
               cnt   <= cnt + 5'd1;
               if (cnt == 5'd31)
                  state <= FIX;
            end
            FIX: begin
               // A zero divisor yields a meaningless quotient from the
               // iterations, so the fixed pattern is substituted here. This
               // keeps the latency identical for that case.
               if (dvs_in == 16'sd0) begin
                  quotient    <= 32'hFFFF_FFFF;
                  remainder   <= dvd_in[15:0];
                  div_by_zero <= 1'b1;
                  overflow    <= 1'b0;
               end else begin
                  quotient    <= cond_neg32(shq, sign_q);
                  remainder   <= cond_neg16(prem, sign_r);
                  div_by_zero <= 1'b0;
                  // The magnitude path already gives 0x80000000 rem 0 here.
                  overflow    <= (dvd_in == 32'sh8000_0000) && (dvs_in == -16'sd1);
               end
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
